// File: rtl/frv_core_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// frv_core_fetch_ctrl
//
// Instruction fetch sequencer for the core front end. Issues word-aligned
// reads on the instruction memory request channel, counts outstanding
// requests, and passes responses combinationally into the fetch buffer.
// On a control-flow redirect the buffer is flushed, and every response still
// in flight is acknowledged and discarded.
//
// Ports
//   g_clk, g_resetn        clock, synchronous active-low reset
//   cf_req/cf_target       redirect request and halfword-aligned target
//   cf_ack                 redirect accepted this cycle
//   imem_req/imem_addr     read request valid and word address
//   imem_gnt               request accepted by memory
//   imem_recv/imem_ack     response valid / response consumed
//   imem_error/imem_rdata  response bus error flag and data
//   buf_flush              fetch buffer flush pulse
//   f_4byte/f_2byte/f_err  buffer push controls (full word / upper half / error)
//   f_in                   data pushed to the buffer
//   f_ready                buffer can accept 4 bytes
// ---------------------------------------------------------------------------
module frv_core_fetch_ctrl #(
  parameter logic [31:0] FRV_PC_RESET_VALUE = 32'h8000_0000,
  parameter int unsigned MAX_OUT            = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cf_req,
  input  logic [31:0] cf_target,
  output logic        cf_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_recv,
  output logic        imem_ack,
  input  logic        imem_error,
  input  logic [31:0] imem_rdata,
  output logic        buf_flush,
  output logic        f_4byte,
  output logic        f_2byte,
  output logic        f_err,
  output logic [31:0] f_in,
  input  logic        f_ready
);

  localparam logic [1:0] MAX_OUT_W = 2'(MAX_OUT);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_addr_reg, fetch_addr_next;
  logic        first_hw_reg, first_hw_next;
  logic [1:0]  n_out_reg, n_out_next;
  logic [1:0]  n_drop_reg, n_drop_next;
  logic        req_hold_reg, req_hold_next;

  logic active;
  logic dropping;
  logic can_issue;
  logic req_fire;
  logic resp_fire;
  logic push;

  // Bit 0 of the redirect target is meaningless for halfword-aligned code.
  logic cf_target_unused;
  assign cf_target_unused = cf_target[0];

  // Outputs are held quiet while in reset and for the RESET state cycle.
  assign active   = g_resetn && (state_reg != ST_RESET);
  assign dropping = (n_drop_reg != 2'd0);

  // A fresh request needs RUN, buffer space, a free outstanding slot and no
  // pending redirect; once raised it is held by req_hold_reg until granted.
  assign can_issue = (state_reg == ST_RUN) && f_ready && (n_out_reg < MAX_OUT_W) && !cf_req;
  assign imem_req  = active && (req_hold_reg || can_issue);
  assign imem_addr = fetch_addr_reg;
  assign req_fire  = imem_req && imem_gnt;

  // Never abandon an ungranted request: redirects wait for its grant.
  assign cf_ack    = active && cf_req && !(imem_req && !imem_gnt);
  assign buf_flush = cf_ack;

  // Stale responses and any response in the redirect cycle are swallowed.
  assign imem_ack  = active && (dropping || f_ready || cf_ack);
  assign resp_fire = imem_recv && imem_ack;
  assign push      = active && imem_recv && f_ready && !dropping && !cf_ack;

  assign f_4byte = push && !first_hw_reg;
  assign f_2byte = push && first_hw_reg;
  assign f_err   = push && imem_error;
  assign f_in    = active ? imem_rdata : 32'h0;

  always_comb begin
    state_next      = state_reg;
    fetch_addr_next = fetch_addr_reg;
    first_hw_next   = first_hw_reg;
    n_drop_next     = n_drop_reg;
    req_hold_next   = imem_req && !imem_gnt;
    n_out_next      = n_out_reg + {1'b0, req_fire} - {1'b0, resp_fire};

    case (state_reg)
      ST_RESET: state_next = ST_RUN;
      ST_RUN:   if (push && imem_error) state_next = ST_HALT;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_RESET;
    endcase

    if (req_fire) fetch_addr_next = fetch_addr_reg + 32'd4;
    if (push)     first_hw_next   = 1'b0;
    if (dropping && resp_fire) n_drop_next = n_drop_reg - 2'd1;

    // Redirect wins over error halt, address increment and drop bookkeeping.
    // Everything still outstanding after this cycle is stale, so the drop
    // count is simply the post-cycle outstanding count.
    if (cf_ack) begin
      state_next      = ST_RUN;
      fetch_addr_next = {cf_target[31:2], 2'b00};
      first_hw_next   = cf_target[1];
      n_drop_next     = n_out_next;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_reg      <= ST_RESET;
      fetch_addr_reg <= FRV_PC_RESET_VALUE;
      first_hw_reg   <= 1'b0;
      n_out_reg      <= 2'd0;
      n_drop_reg     <= 2'd0;
      req_hold_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_addr_reg <= fetch_addr_next;
      first_hw_reg   <= first_hw_next;
      n_out_reg      <= n_out_next;
      n_drop_reg     <= n_drop_next;
      req_hold_reg   <= req_hold_next;
    end
  end

endmodule

// File: tb/tb_frv_core_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frv_core_fetch_ctrl
//
// Randomized bench for the fetch controller. A behavioural memory keeps a
// queue of granted reads; each grant of the live fetch stream pushes the
// expected buffer write into a scoreboard queue, and a monitor pops and
// compares whenever the DUT pushes into the buffer. Redirects mark every
// in-flight read stale and empty the scoreboard.
// ---------------------------------------------------------------------------
module tb_frv_core_fetch_ctrl;

  localparam logic [31:0] PC_RST = 32'h8000_0000;
  localparam int          MAXO   = 2;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        cf_req = 1'b0;
  logic [31:0] cf_target = 32'h0;
  logic        cf_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_recv = 1'b0;
  logic        imem_ack;
  logic        imem_error = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        buf_flush;
  logic        f_4byte;
  logic        f_2byte;
  logic        f_err;
  logic [31:0] f_in;
  logic        f_ready = 1'b0;

  frv_core_fetch_ctrl #(
    .FRV_PC_RESET_VALUE(PC_RST),
    .MAX_OUT           (MAXO)
  ) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .cf_req    (cf_req),
    .cf_target (cf_target),
    .cf_ack    (cf_ack),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_gnt  (imem_gnt),
    .imem_recv (imem_recv),
    .imem_ack  (imem_ack),
    .imem_error(imem_error),
    .imem_rdata(imem_rdata),
    .buf_flush (buf_flush),
    .f_4byte   (f_4byte),
    .f_2byte   (f_2byte),
    .f_err     (f_err),
    .f_in      (f_in),
    .f_ready   (f_ready)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    bit          stale;
  } mem_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          hw;
  } exp_t;

  mem_t inflight[$];
  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] next_addr  = PC_RST;
  bit          first_hw_m = 1'b0;
  bit          halted     = 1'b0;
  bit          req_held   = 1'b0;
  bit          resp_on    = 1'b0;
  bit          cf_pending = 1'b0;
  int          since_rel  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0:       t = 32'h0000_1002;
      1:       t = 32'h0000_0200;
      2:       t = 32'hFFFF_FFF6;   // halfword target near the top: forces wrap
      3:       t = 32'hFFFF_FFF9;   // bit 0 set, must be ignored
      default: t = $urandom;
    endcase
    return t;
  endfunction

  // Scoreboard monitor: every buffer push must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge g_clk);
      if (g_resetn && (f_4byte || f_2byte)) begin
        if (exp_q.size() == 0) begin
          check("push_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("f_in", f_in, e.data);
          check("f_err", {31'd0, f_err}, {31'd0, e.err});
          check("f_2byte", {31'd0, f_2byte}, {31'd0, e.hw});
          check("f_4byte", {31'd0, f_4byte}, {31'd0, !e.hw});
        end
      end
    end
  end

  task automatic reset_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge g_clk); #1;
      g_resetn   = 1'b0;
      cf_req     = 1'b0;
      imem_gnt   = 1'b0;
      imem_recv  = 1'b0;
      imem_error = 1'b0;
      imem_rdata = $urandom;
      f_ready    = 1'($urandom_range(0, 1));
      @(negedge g_clk); #1;
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_imem_ack", {31'd0, imem_ack}, 32'd0);
      check("rst_cf_ack", {31'd0, cf_ack}, 32'd0);
      check("rst_flush", {31'd0, buf_flush}, 32'd0);
      check("rst_push", {30'd0, f_4byte, f_2byte}, 32'd0);
      check("rst_f_err", {31'd0, f_err}, 32'd0);
      check("rst_f_in", f_in, 32'd0);
      if (i > 0) check("rst_imem_addr", imem_addr, PC_RST);
    end
    inflight.delete();
    exp_q.delete();
    next_addr  = PC_RST;
    first_hw_m = 1'b0;
    halted     = 1'b0;
    req_held   = 1'b0;
    resp_on    = 1'b0;
    cf_pending = 1'b0;
    since_rel  = 0;
  endtask

  // mode 0: fully random; mode 1: no new redirects; mode 2: no grants,
  // buffer always ready, responses returned as fast as possible.
  task automatic cycle(input int mode);
    bit   exp_req, exp_cfack, ack_m, push_m;
    mem_t fr;
    mem_t m;
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    if (!resp_on && inflight.size() > 0 && (mode == 2 || $urandom_range(0, 99) < 55))
      resp_on = 1'b1;
    imem_recv = resp_on;
    if (resp_on) begin
      imem_rdata = inflight[0].data;
      imem_error = inflight[0].err;
    end else begin
      imem_rdata = $urandom;
      imem_error = 1'($urandom_range(0, 1));
    end
    imem_gnt = (mode == 2) ? 1'b0 : ($urandom_range(0, 99) < 70);
    f_ready  = (mode == 2) ? 1'b1 : ($urandom_range(0, 99) < 80);
    if (!cf_pending && mode == 0 && since_rel > 0 &&
        $urandom_range(0, 99) < (halted ? 25 : 4)) begin
      cf_pending = 1'b1;
      cf_target  = pick_target();
    end
    cf_req = cf_pending;

    @(negedge g_clk); #1;
    // Request channel: a held request persists; a new one needs run mode,
    // buffer space, a free slot and no redirect pending.
    exp_req = req_held ||
              (since_rel > 0 && !halted && f_ready && inflight.size() < MAXO && !cf_req);
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, next_addr);

    exp_cfack = cf_req && !(exp_req && !imem_gnt);
    check("cf_ack", {31'd0, cf_ack}, {31'd0, exp_cfack});
    check("buf_flush", {31'd0, buf_flush}, {31'd0, exp_cfack});

    ack_m  = 1'b0;
    push_m = 1'b0;
    if (imem_recv) begin
      fr = inflight[0];
      if (fr.stale || exp_cfack) begin
        ack_m = 1'b1;
      end else begin
        ack_m  = f_ready;
        push_m = f_ready;
      end
      check("imem_ack", {31'd0, imem_ack}, {31'd0, ack_m});
      if (push_m && fr.err) halted = 1'b1;
    end
    check("push", {31'd0, f_4byte | f_2byte}, {31'd0, push_m});

    if (imem_recv && ack_m) begin
      void'(inflight.pop_front());
      resp_on = 1'b0;
    end

    if (exp_req && imem_gnt) begin
      m.addr  = next_addr;
      m.data  = mem_data(next_addr);
      m.err   = ($urandom_range(0, 99) < 4);
      m.stale = 1'b0;
      inflight.push_back(m);
      exp_q.push_back('{m.data, m.err, first_hw_m});
      first_hw_m = 1'b0;
      next_addr  = next_addr + 32'd4;
    end
    req_held = exp_req && !imem_gnt;

    if (exp_cfack) begin
      foreach (inflight[k]) inflight[k].stale = 1'b1;
      exp_q.delete();
      next_addr  = {cf_target[31:2], 2'b00};
      first_hw_m = cf_target[1];
      halted     = 1'b0;
      cf_pending = 1'b0;
    end
    since_rel++;
  endtask

  initial begin
    reset_phase(4);
    for (int i = 0; i < 1500; i++) cycle(0);
    reset_phase(3);
    for (int i = 0; i < 1500; i++) cycle(0);
    for (int i = 0; i < 40; i++) cycle(1);
    for (int i = 0; i < 20; i++) cycle(2);
    check("drain_inflight", inflight.size(), 32'd0);
    check("drain_scoreboard", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
